pc_register: RTL and testbench
==============================

Name:
pc_register

Overview:
- Program-counter storage register for the simple processor datapath.
- Holds the current instruction address.
- Loads a new address from the next-PC logic when write is enabled.
- Presents the stored address to the fetch stage only when read is enabled.
- Single clock domain; one instance per core.

Parameters:
- WIDTH, 32: bit width of the stored address and of the data ports.
- RESET_VALUE, 0: value loaded into the register on reset.

Ports:
- i_clk  input  1  system clock; all state updates on the rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_data  input  WIDTH  next-PC value to be loaded.
- i_readEn  input  1  output enable for o_data.
- i_writeEn  input  1  load enable for the PC register.
- o_data  output  WIDTH  current PC value, gated by i_readEn.

Behaviour:
- Interface: one clock (i_clk); reset i_rst is asynchronous and active-high.
- Storage: one WIDTH-bit register pc_q.
- Reset:
  - i_rst high clears pc_q to RESET_VALUE immediately, independent of i_clk.
  - o_data then reads RESET_VALUE if i_readEn=1, otherwise 0.
- Reset mid-operation: an asserted i_rst overrides any write in the same cycle.
- Reset release: the first load happens at the first rising edge of i_clk with i_rst low and i_writeEn=1.
- Write:
  - On a rising edge of i_clk with i_rst=0 and i_writeEn=1, pc_q <= i_data.
  - Latency 1 cycle: the new value is visible on o_data after that edge.
  - With i_writeEn=0, pc_q holds its value indefinitely.
- Read:
  - o_data is combinational from pc_q: o_data = i_readEn ? pc_q : 0.
  - No clock latency on the enable; o_data is never high-Z.
- Simultaneous read and write (both enables 1):
  - o_data shows the pre-edge (old) pc_q during the cycle.
  - The new value appears after the edge.
- No arithmetic, no increment and no overflow: the value stored equals i_data bit for bit, all WIDTH bits including the MSB.
- i_readEn has no effect on storage; i_writeEn has no effect on o_data within the current cycle.
- i_data is sampled only at the rising edge; changes between edges are ignored.
- No X propagation from an idle i_data when i_writeEn=0.

Optional Feature:
- Macro: PC_REGISTER_BYPASS_EN.
- Defined: write-through forwarding.
  - When i_readEn=1 and i_writeEn=1, o_data = i_data combinationally in the same cycle.
  - This replaces the old pc_q; the register still updates at the edge as normal.
  - With i_writeEn=0, behaviour is identical to the non-bypass build.
  - i_rst high still forces o_data to RESET_VALUE (or 0 when i_readEn=0), with no forwarding.
- Not defined: no forwarding; the simultaneous read/write rule in Behaviour applies.

Test Plan:
- Reset: assert i_rst asynchronously between edges with i_readEn=1 and pc_q=0x1F -> o_data becomes 0x00000000 before the next edge; a write held during reset is ignored.
- Write-only: i_readEn=0, i_writeEn=1, i_data=0..31 on successive edges -> o_data stays 0 throughout; pc_q ends at 31 (check by raising i_readEn -> o_data=0x1F).
- Read-only: i_readEn=1, i_writeEn=0, i_data sweeping 0..31 -> o_data constant 0x1F for all 32 cycles.
- Read+write, no bypass: both enables 1, i_data=32..63 per edge -> o_data lags by one cycle (shows 31, 32, …, 62), then 63 after the final edge.
- Bypass build (PC_REGISTER_BYPASS_EN defined): same stimulus -> o_data equals i_data in the same cycle (32..63); with i_writeEn=0, o_data=pc_q.
- Width boundary: write 0xFFFFFFFF, then 0x80000000 -> read back exactly, no truncation or sign effects; toggling i_readEn 1→0→1 gives 0x80000000, 0, 0x80000000 with no edge required.

Source files
------------

// File: rtl/pc_register.sv
`default_nettype none
// ============================================================================
// Module   : pc_register
// Brief    : Program-counter storage register with gated combinational read.
//            Optional macro PC_REGISTER_BYPASS_EN enables write-through forwarding.
// Revision : 1.0  initial release
// ============================================================================
module pc_register #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_readEn,
    input  logic             i_writeEn,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;

    // Idle i_data never reaches the register while the write enable is low.
    always_comb begin
        pc_d = pc_q;
        if (i_writeEn) begin
            pc_d = i_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pc_q <= RESET_VALUE;
        end else begin
            pc_q <= pc_d;
        end
    end

`ifdef PC_REGISTER_BYPASS_EN
    // Forward the incoming address, except while reset holds the register.
    always_comb begin
        o_data = '0;
        if (i_readEn) begin
            if (i_writeEn && !i_rst) begin
                o_data = i_data;
            end else begin
                o_data = pc_q;
            end
        end
    end
`else
    always_comb begin
        o_data = '0;
        if (i_readEn) begin
            o_data = pc_q;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_register.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_register
// Brief    : Self-checking bench for pc_register with an abstract PC model.
// Revision : 1.0  initial release
// ============================================================================
module tb_pc_register;

    localparam int          WIDTH = 32;
    localparam logic [31:0] RV    = 32'h0000_0000;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] data;
    logic             re;
    logic             we;
    logic [WIDTH-1:0] dout;

    logic [WIDTH-1:0] model_pc;
    logic             check_en;
    int               n_pass;
    int               n_total;

    pc_register #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RV)
    ) u_dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_data    (data),
        .i_readEn  (re),
        .i_writeEn (we),
        .o_data    (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] exp_out();
        if (!re) return '0;
`ifdef PC_REGISTER_BYPASS_EN
        if (we && !rst) return data;
`endif
        return model_pc;
    endfunction

    // Reset takes effect on the model at the moment it is asserted.
    task automatic drive(input logic r, input logic rd, input logic wr,
                         input logic [WIDTH-1:0] d);
        rst  = r;
        re   = rd;
        we   = wr;
        data = d;
        if (r) model_pc = RV;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst && we) model_pc = data;
        #1;
    endtask

    always @(negedge clk) begin
        if (check_en) check("cycle", dout, exp_out());
    end

    initial begin
        logic        bypass;
        logic [31:0] saved;
        n_pass   = 0;
        n_total  = 0;
        check_en = 1'b0;
        model_pc = RV;
`ifdef PC_REGISTER_BYPASS_EN
        bypass = 1'b1;
`else
        bypass = 1'b0;
`endif

        drive(1'b1, 1'b1, 1'b0, 32'h0);
        #1 check("reset_read", dout, 32'h0);
        re = 1'b0;
        #1 check("reset_noread", dout, 32'h0);
        tick();
        tick();
        check_en = 1'b1;

        // Write-only: output stays zero while loading 0..31.
        for (int k = 0; k < 32; k++) begin
            drive(1'b0, 1'b0, 1'b1, 32'(k));
            #1 check("wo_out", dout, 32'h0);
            tick();
        end
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        #1 check("wo_final", dout, 32'h1F);

        // Read-only sweep: stored value unaffected.
        for (int k = 0; k < 32; k++) begin
            drive(1'b0, 1'b1, 1'b0, 32'(k));
            #1 check("ro_out", dout, 32'h1F);
            tick();
        end

        // Simultaneous read and write of 32..63.
        for (int k = 0; k < 32; k++) begin
            drive(1'b0, 1'b1, 1'b1, 32'(32 + k));
            #1 check("rw_out", dout, bypass ? 32'(32 + k) : 32'(31 + k));
            tick();
        end
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        #1 check("rw_final", dout, 32'd63);
        tick();

        // Width boundary: full ones then MSB only.
        drive(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF);
        tick();
        drive(1'b0, 1'b1, 1'b1, 32'h8000_0000);
        #1 check("wb_ones", dout, bypass ? 32'h8000_0000 : 32'hFFFF_FFFF);
        tick();
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        #1 check("wb_msb", dout, 32'h8000_0000);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        #1 check("wb_gate", dout, 32'h0);
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        #1 check("wb_msb2", dout, 32'h8000_0000);
        tick();

        // Asynchronous reset between edges, with a write held during reset.
        drive(1'b0, 1'b1, 1'b1, 32'h1F);
        tick();
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        #1 check("ar_pre", dout, 32'h1F);
        #1 drive(1'b1, 1'b1, 1'b1, 32'hAA);
        #1 check("ar_async", dout, 32'h0);
        tick();
        check("ar_hold", dout, 32'h0);
        drive(1'b0, 1'b1, 1'b0, 32'h5);
        #1 check("ar_release", dout, 32'h0);
        tick();
        drive(1'b0, 1'b1, 1'b1, 32'h7);
        tick();
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        #1 check("ar_firstload", dout, 32'h7);
        tick();

        // Randomized traffic with mid-cycle i_data glitches.
        for (int k = 0; k < 400; k++) begin
            drive($urandom_range(0, 39) == 0, 1'($urandom), 1'($urandom), $urandom);
            if ($urandom_range(0, 3) == 0) begin
                saved = data;
                @(negedge clk);
                #1 data = $urandom;
                #1 data = saved;
            end
            tick();
        end

        check_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
